// File: rtl/accel_seq_ctrl.sv
// Accelerometer sequencer: DEVICEID check, configuration writes, then periodic
// six-byte axis bursts over the spi_phy host_req/host_ack handshake.
module accel_seq_ctrl #(
    parameter int         REQ_DATA_WIDTH = 16,
    parameter int         ACK_DATA_WIDTH = 8,
    parameter int         SAMPLE_PERIOD  = 20000,
    parameter int         TIMEOUT        = 64,
    parameter int         GAP_CYCLES     = 2,
    parameter logic [7:0] DEVID_EXP      = 8'hE5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    output logic                      host_req,
    output logic [REQ_DATA_WIDTH-1:0] host_req_data,
    input  logic                      host_ack,
    input  logic [ACK_DATA_WIDTH-1:0] host_ack_data,
    output logic [15:0]               accel_x,
    output logic [15:0]               accel_y,
    output logic [15:0]               accel_z,
    output logic                      sample_valid,
    output logic                      init_done,
    output logic                      dev_err
);

    localparam logic [2:0] ST_GAP         = 3'd0;
    localparam logic [2:0] ST_ISSUE       = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK    = 3'd2;
    localparam logic [2:0] ST_SAMPLE_WAIT = 3'd3;
    localparam logic [2:0] ST_PARK        = 3'd4;

    localparam logic [3:0] STEP_DEVID    = 4'd0;
    localparam logic [3:0] STEP_LAST_CFG = 4'd3;
    localparam logic [3:0] STEP_AXIS0    = 4'd4;
    localparam logic [3:0] STEP_AXIS_END = 4'd9;

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

    logic [2:0]                           state;
    logic [3:0]                           step;
    logic [GW-1:0]                        gap_cnt;
    logic [WW-1:0]                        wait_cnt;
    logic [PW-1:0]                        period_cnt;
    logic [5:0][ACK_DATA_WIDTH-1:0]       shadow;

    // Command word for each sequence step: reads {1,0,addr,00}, writes {0,0,addr,data}.
    function automatic logic [15:0] step_word(input logic [3:0] s);
        case (s)
            4'd0:    return 16'h8000;
            4'd1:    return 16'h310B;
            4'd2:    return 16'h2C0A;
            4'd3:    return 16'h2D08;
            default: return {2'b10, 6'h32 + {2'b00, s - STEP_AXIS0}, 8'h00};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_GAP;
            step          <= STEP_DEVID;
            gap_cnt       <= '0;
            wait_cnt      <= '0;
            period_cnt    <= '0;
            shadow        <= '0;
            host_req      <= 1'b0;
            host_req_data <= '0;
            accel_x       <= '0;
            accel_y       <= '0;
            accel_z       <= '0;
            sample_valid  <= 1'b0;
            init_done     <= 1'b0;
            dev_err       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            gap_cnt      <= '0;
            case (state)
                ST_GAP: begin
                    host_req <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        // Parking is only allowed on a burst/sequence boundary.
                        if (!enable && (step == STEP_DEVID || step == STEP_AXIS0))
                            state <= ST_PARK;
                        else
                            state <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    host_req_data <= REQ_DATA_WIDTH'(step_word(step));
                    host_req      <= 1'b1;
                    wait_cnt      <= '0;
                    state         <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (host_ack) begin
                        host_req <= 1'b0;
                        state    <= ST_GAP;
                        if (step == STEP_DEVID) begin
                            if (host_ack_data != DEVID_EXP) begin
                                dev_err    <= 1'b1;
                                init_done  <= 1'b0;
                                period_cnt <= '0;
                                state      <= ST_SAMPLE_WAIT;
                            end else begin
                                dev_err <= 1'b0;
                                step    <= step + 4'd1;
                            end
                        end else if (step <= STEP_LAST_CFG) begin
                            if (step == STEP_LAST_CFG)
                                init_done <= 1'b1;
                            step <= step + 4'd1;
                        end else begin
                            shadow[3'(step - STEP_AXIS0)] <= host_ack_data;
                            if (step == STEP_AXIS_END) begin
                                // Last byte bypasses the shadow so all axes update in one edge.
                                accel_x      <= {shadow[1], shadow[0]};
                                accel_y      <= {shadow[3], shadow[2]};
                                accel_z      <= {host_ack_data, shadow[4]};
                                sample_valid <= 1'b1;
                                period_cnt   <= '0;
                                state        <= ST_SAMPLE_WAIT;
                            end else begin
                                step <= step + 4'd1;
                            end
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        host_req  <= 1'b0;
                        dev_err   <= 1'b1;
                        init_done <= 1'b0;
                        step      <= STEP_DEVID;
                        state     <= ST_GAP;
                    end else if (wait_cnt < WAIT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SAMPLE_WAIT: begin
                    host_req <= 1'b0;
                    if (period_cnt == PER_LAST) begin
                        step  <= init_done ? STEP_AXIS0 : STEP_DEVID;
                        state <= ST_GAP;
                    end else if (period_cnt < PER_LAST) begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                ST_PARK: begin
                    host_req <= 1'b0;
                    if (enable)
                        state <= ST_GAP;
                end
                default: begin
                    host_req <= 1'b0;
                    state    <= ST_GAP;
                end
            endcase
        end
    end

endmodule
